// File: rtl/cache_mshr.sv
// cache_mshr: in-order miss queue that issues single-beat bus cycles and returns completions
module cache_mshr #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid_i,
  input  logic [AW-1:0]           load_adr_i,
  input  logic [DW-1:0]           load_dat_i,
  input  logic                    load_we_i,
  output logic                    load_ready_o,
  output logic                    deload_valid_o,
  output logic [AW-1:0]           deload_adr_o,
  output logic [DW-1:0]           deload_dat_o,
  output logic                    deload_we_o,
  output logic                    deload_err_o,
  input  logic                    deload_ready_i,
  input  logic [AW-1:0]           lookup_adr_i,
  output logic                    lookup_hit_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    cyc_m2s,
  output logic                    we_m2s,
  output logic [AW-1:0]           adr_m2s,
  output logic [DW-1:0]           dat_m2s,
  input  logic [DW-1:0]           dat_mem_i,
  input  logic                    ack_mem_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state;
  logic [AW-1:0] adr_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] we_q, done_q, err_q;
  logic [PW-1:0] wr, iss, rd;
  logic [TW-1:0] tmo;
  logic load_fire, deload_fire, pending;
  assign load_ready_o = count_o < CW'(DEPTH);
  assign deload_valid_o = (count_o != '0) && done_q[rd];
  assign deload_adr_o = adr_q[rd];
  assign deload_dat_o = dat_q[rd];
  assign deload_we_o = we_q[rd];
  assign deload_err_o = err_q[rd];
  assign load_fire = load_valid_i && load_ready_o;
  assign deload_fire = deload_valid_o && deload_ready_i;
  // a full queue with iss==wr still has work when the entry there has not completed
  assign pending = (iss != wr) || (count_o == CW'(DEPTH) && !done_q[iss]);
  // probe every occupied slot, measured as its distance from the read pointer
  always_comb begin
    lookup_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, PW'(i) - rd} < count_o && adr_q[i] == lookup_adr_i) lookup_hit_o = 1'b1;
  end
  // queue bookkeeping plus the IDLE/BUS issue engine with timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      iss <= '0;
      rd <= '0;
      count_o <= '0;
      state <= IDLE;
      tmo <= '0;
      cyc_m2s <= 1'b0;
      we_m2s <= 1'b0;
      adr_m2s <= '0;
      dat_m2s <= '0;
      we_q <= '0;
      done_q <= '0;
      err_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      count_o <= count_o + CW'(load_fire) - CW'(deload_fire);
      if (load_fire) begin
        adr_q[wr] <= load_adr_i;
        dat_q[wr] <= load_dat_i;
        we_q[wr] <= load_we_i;
        done_q[wr] <= 1'b0;
        err_q[wr] <= 1'b0;
        wr <= wr + 1'b1;
      end
      if (deload_fire) rd <= rd + 1'b1;
      if (state == IDLE) begin
        if (pending) begin
          state <= BUS;
          cyc_m2s <= 1'b1;
          we_m2s <= we_q[iss];
          adr_m2s <= adr_q[iss];
          dat_m2s <= dat_q[iss];
          tmo <= '0;
        end
      end else if (ack_mem_i || tmo == TW'(TIMEOUT - 1)) begin
        if (ack_mem_i && !we_q[iss]) dat_q[iss] <= dat_mem_i;
        done_q[iss] <= 1'b1;
        err_q[iss] <= !ack_mem_i;
        iss <= iss + 1'b1;
        state <= IDLE;
        cyc_m2s <= 1'b0;
        we_m2s <= 1'b0;
      end else tmo <= tmo + 1'b1;
    end
endmodule

// File: tb/tb_cache_mshr.sv
// tb_cache_mshr: scoreboard bench for the miss queue with a scripted memory responder
module tb_cache_mshr;
  logic clk = 1'b0, rst = 1'b1;
  logic load_valid_i = 1'b0, load_we_i = 1'b0, deload_ready_i = 1'b0, ack_mem_i = 1'b0;
  logic [7:0] load_adr_i = '0, load_dat_i = '0, lookup_adr_i = '0, dat_mem_i = '0;
  logic load_ready_o, deload_valid_o, deload_we_o, deload_err_o, lookup_hit_o;
  logic cyc_m2s, we_m2s;
  logic [7:0] deload_adr_o, deload_dat_o, adr_m2s, dat_m2s;
  logic [2:0] count_o;

  cache_mshr dut (
    .clk(clk), .rst(rst),
    .load_valid_i(load_valid_i), .load_adr_i(load_adr_i), .load_dat_i(load_dat_i),
    .load_we_i(load_we_i), .load_ready_o(load_ready_o),
    .deload_valid_o(deload_valid_o), .deload_adr_o(deload_adr_o), .deload_dat_o(deload_dat_o),
    .deload_we_o(deload_we_o), .deload_err_o(deload_err_o), .deload_ready_i(deload_ready_i),
    .lookup_adr_i(lookup_adr_i), .lookup_hit_o(lookup_hit_o), .count_o(count_o),
    .cyc_m2s(cyc_m2s), .we_m2s(we_m2s), .adr_m2s(adr_m2s), .dat_m2s(dat_m2s),
    .dat_mem_i(dat_mem_i), .ack_mem_i(ack_mem_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] adr; logic [7:0] dat; logic we; logic err;} dl_t;
  typedef struct packed {logic [7:0] adr; logic we; logic [7:0] dat;} bus_t;
  dl_t dl_q[$];
  bus_t bus_q[$];
  int errors = 0, checks = 0;
  int ack_wait = 0, wcnt = 0, last_len = 0;
  logic xor_mode = 1'b0;
  logic [7:0] mem_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d, input logic w,
                      input logic [7:0] fill, input logic err);
    int n = 0;
    while (!load_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!load_ready_o) begin
      checks++;
      errors++;
      $display("FAIL load_wait: load_ready_o stuck low for adr %0h", a);
    end
    load_valid_i = 1'b1;
    load_adr_i = a;
    load_dat_i = d;
    load_we_i = w;
    tick();
    load_valid_i = 1'b0;
    dl_q.push_back({a, (w || err) ? d : fill, w, err});
    bus_q.push_back({a, w, d});
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (count_o != 0 && n < 200) begin
      tick();
      n++;
    end
    check(name, count_o, 0);
  endtask

  // memory responder: acks after ack_wait cycles of cyc (never when negative)
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (cyc_m2s) begin
        if (wcnt == 0) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: adr %0h with no queued expectation", adr_m2s);
          end else begin
            b = bus_q.pop_front();
            check("bus_cycle", {adr_m2s, we_m2s, dat_m2s}, b);
          end
        end
        ack_mem_i = (wcnt == ack_wait);
        dat_mem_i = xor_mode ? ~adr_m2s : mem_data;
        wcnt++;
      end else begin
        if (wcnt != 0) last_len = wcnt;
        ack_mem_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // deload monitor: every retired entry is matched against the scoreboard
  initial begin
    dl_t e;
    forever begin
      @(negedge clk);
      if (!rst && deload_valid_o && deload_ready_i) begin
        if (dl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deload_unexpected: adr %0h with no queued expectation", deload_adr_o);
        end else begin
          e = dl_q.pop_front();
          check("deload", {deload_adr_o, deload_dat_o, deload_we_o, deload_err_o}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cyc", cyc_m2s, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", load_ready_o, 1);
    check("rst_valid", deload_valid_o, 0);
    check("rst_hit", lookup_hit_o, 0);
    tick();
    rst = 1'b0;
    tick();
    // read miss with two wait states
    ack_wait = 2;
    mem_data = 8'hA5;
    deload_ready_i = 1'b1;
    load(8'h12, 8'h00, 1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    check("t1_count_busy", count_o, 1);
    wait_empty("t1_count_done");
    // write miss, zero-wait, latency measured with deload held off
    ack_wait = 0;
    deload_ready_i = 1'b0;
    load(8'h30, 8'h5C, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("t2_valid_e1", deload_valid_o, 0);
    check("t2_cyc_e1", cyc_m2s, 0);
    @(negedge clk);
    check("t2_valid_e2", deload_valid_o, 0);
    check("t2_cyc_e2", cyc_m2s, 1);
    @(negedge clk);
    check("t2_valid_e3", deload_valid_o, 1);
    check("t2_dat", deload_dat_o, 8'h5C);
    tick();
    deload_ready_i = 1'b1;
    wait_empty("t2_drain");
    // fill the queue, refuse a fifth entry, drain in order
    deload_ready_i = 1'b0;
    xor_mode = 1'b1;
    for (int i = 0; i < 4; i++) load(8'(i), 8'h00, 1'b0, ~8'(i), 1'b0);
    check("t3_ready_full", load_ready_o, 0);
    check("t3_count_full", count_o, 4);
    load_valid_i = 1'b1;
    load_adr_i = 8'h99;
    load_we_i = 1'b0;
    tick();
    tick();
    load_valid_i = 1'b0;
    check("t3_refused", count_o, 4);
    deload_ready_i = 1'b1;
    wait_empty("t3_drain");
    // timeout: no ack ever arrives
    xor_mode = 1'b0;
    ack_wait = -1;
    load(8'h55, 8'h00, 1'b0, 8'h00, 1'b1);
    wait_empty("t4_drain");
    check("t4_cyc_len", last_len, 15);
    // lookup over occupied entries
    ack_wait = 0;
    xor_mode = 1'b1;
    deload_ready_i = 1'b0;
    load(8'h40, 8'h00, 1'b0, 8'hBF, 1'b0);
    load(8'h41, 8'h00, 1'b0, 8'hBE, 1'b0);
    lookup_adr_i = 8'h41;
    @(negedge clk);
    check("t5_hit_41", lookup_hit_o, 1);
    lookup_adr_i = 8'h42;
    @(negedge clk);
    check("t5_miss_42", lookup_hit_o, 0);
    lookup_adr_i = 8'h40;
    @(negedge clk);
    check("t5_hit_40", lookup_hit_o, 1);
    tick();
    deload_ready_i = 1'b1;
    wait_empty("t5_drain");
    lookup_adr_i = 8'h41;
    @(negedge clk);
    check("t5_freed_41", lookup_hit_o, 0);
    // asynchronous reset in the middle of a bus cycle
    ack_wait = -1;
    load(8'h77, 8'h00, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!cyc_m2s && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_cyc_before", cyc_m2s, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_cyc", cyc_m2s, 0);
    check("t6_count", count_o, 0);
    check("t6_ready", load_ready_o, 1);
    dl_q.delete();
    bus_q.delete();
    tick();
    rst = 1'b0;
    ack_wait = 0;
    tick();
    @(negedge clk);
    check("t6_valid_after", deload_valid_o, 0);
    check("t6_cyc_after", cyc_m2s, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
